// File: rtl/snd_rcv_agg_sched_if.sv
// rtl/snd_rcv_agg_sched_if.sv - requester/aggregator handshake bundle for snd_rcv_agg_sched
//
// Purpose: groups the K requester beat channels, the single aggregator beat
// channel, the grant/source status and the stall error flag into one bundle.
//
// Signals:
//   req_vld   [K]     per-requester beat valid
//   req_data  [K*N]   per-requester beat, requester i at [i*N +: N]
//   req_rdy   [K]     per-requester ready
//   agg_vld           beat valid toward the aggregator
//   agg_data  [N]     beat toward the aggregator
//   agg_rdy           aggregator ready
//   agg_last          last beat of a burst
//   agg_src   [KW]    index of the granted requester
//   grant     [K]     one-hot grant, zero outside a burst
//   err_stall         sticky stall-timeout flag
//   err_clr           clears err_stall
//
// Modports: master = scheduler side, slave = requesters/aggregator side.
interface snd_rcv_agg_sched_if #(
  parameter int K = 4,
  parameter int N = 4
);
  localparam int KW = $clog2(K);

  logic [K-1:0]   req_vld;
  logic [K*N-1:0] req_data;
  logic [K-1:0]   req_rdy;
  logic           agg_vld;
  logic [N-1:0]   agg_data;
  logic           agg_rdy;
  logic           agg_last;
  logic [KW-1:0]  agg_src;
  logic [K-1:0]   grant;
  logic           err_stall;
  logic           err_clr;

  modport master (
    input  req_vld, req_data, agg_rdy, err_clr,
    output req_rdy, agg_vld, agg_data, agg_last, agg_src, grant, err_stall
  );

  modport slave (
    output req_vld, req_data, agg_rdy, err_clr,
    input  req_rdy, agg_vld, agg_data, agg_last, agg_src, grant, err_stall
  );
endinterface

// File: rtl/snd_rcv_agg_sched.sv
// rtl/snd_rcv_agg_sched.sv - round-robin burst scheduler feeding one shared aggregator
//
// Purpose: K requesters share one aggregator that consumes bursts of M narrow
// beats. A requester is granted round-robin from rr_ptr, keeps the grant for
// a full M-beat burst, and the scheduler spends one IDLE cycle between bursts.
// A burst that makes no progress for TMO cycles raises a sticky err_stall but
// is never aborted.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   snd_rcv_agg_sched_if.master (requester channels, aggregator channel,
//         grant/agg_src status, err_stall/err_clr)
module snd_rcv_agg_sched #(
  parameter int K   = 4,
  parameter int N   = 4,
  parameter int M   = 2,
  parameter int TMO = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  snd_rcv_agg_sched_if.master  bus
);

  localparam int KW = $clog2(K);
  localparam int BW = $clog2(M) + 1;
  localparam int SW = $clog2(TMO + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] rr_q, rr_d;
  logic [KW-1:0] src_q, src_d;
  logic [K-1:0]  grant_q, grant_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;

  logic          pick_found;
  logic [KW-1:0] pick_idx;
  logic [KW-1:0] scan_idx;
  logic          accept;
  logic          last_beat;
  logic          stall_set;

  // (base + off) mod K without relying on K being a power of two
  function automatic logic [KW-1:0] wrap_add(input logic [KW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= K) s = s - K;
    return KW'(s);
  endfunction

  // First requesting index at or cyclically after rr_ptr
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < K; i++) begin
      scan_idx = wrap_add(rr_q, i);
      if (!pick_found && bus.req_vld[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign accept    = (state_q == BURST) && bus.req_vld[src_q] && bus.agg_rdy;
  assign last_beat = (state_q == BURST) && (beat_q == BW'(M - 1));
  // Fires only on the cycle the stall count arrives at TMO, so a saturated
  // stall does not keep re-setting the flag and err_clr can take effect.
  assign stall_set = (state_q == BURST) && !accept && (stall_q == SW'(TMO - 1));

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    src_d   = src_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    err_d   = err_q;

    bus.req_rdy  = '0;
    bus.agg_vld  = 1'b0;
    bus.agg_data = bus.req_data[src_q*N +: N];

    case (state_q)
      IDLE: begin
        beat_d  = '0;
        stall_d = '0;
        if (pick_found) begin
          src_d   = pick_idx;
          grant_d = K'(1) << pick_idx;
          state_d = BURST;
        end
      end
      BURST: begin
        bus.agg_vld = bus.req_vld[src_q];
        bus.req_rdy = K'(bus.agg_rdy) << src_q;
        if (accept) begin
          stall_d = '0;
          if (last_beat) begin
            beat_d  = '0;
            rr_d    = wrap_add(src_q, 1);
            grant_d = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else if (stall_q != SW'(TMO)) begin
          stall_d = stall_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (stall_set) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end

    // Handshake outputs are silenced for the whole reset cycle, not just after it
    if (rst) begin
      bus.agg_vld = 1'b0;
      bus.req_rdy = '0;
    end
  end

  assign bus.agg_last  = last_beat && !rst;
  assign bus.agg_src   = src_q;
  assign bus.grant     = grant_q;
  assign bus.err_stall = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      src_q   <= '0;
      grant_q <= '0;
      beat_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_snd_rcv_agg_sched.sv
// tb/tb_snd_rcv_agg_sched.sv - scoreboard bench for snd_rcv_agg_sched
module tb_snd_rcv_agg_sched;

  logic clk;
  logic rst;

  snd_rcv_agg_sched_if #(.K(4), .N(4)) bus ();

  snd_rcv_agg_sched #(.K(4), .N(4), .M(2), .TMO(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0] src;
    logic [3:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    checks   = 0;
  int    failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [3:0] d, input logic l);
    beat_t b;
    b.src  = s;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Monitor: every accepted beat must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.agg_vld && bus.agg_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=src%0d required=no_beat", bus.agg_src);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_src",   bus.agg_src,  mon_e.src);
        check("beat_data",  bus.agg_data, mon_e.data);
        check("beat_last",  bus.agg_last, mon_e.last);
        check("beat_grant", bus.grant,    32'(1) << mon_e.src);
      end
    end
  end

  logic [3:0] g_tab [9];
  logic       l_tab [9];

  initial begin
    g_tab = '{4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    l_tab = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset with every requester asking: nothing may leak out
    rst          = 1'b1;
    bus.req_vld  = 4'b1111;
    bus.req_data = 16'hC3A5;
    bus.agg_rdy  = 1'b1;
    bus.err_clr  = 1'b0;
    tick();
    tick();
    check("rst_grant",   bus.grant,     0);
    check("rst_src",     bus.agg_src,   0);
    check("rst_err",     bus.err_stall, 0);
    check("rst_agg_vld", bus.agg_vld,   0);
    check("rst_req_rdy", bus.req_rdy,   0);
    check("rst_last",    bus.agg_last,  0);

    // Round robin between requesters 1 and 3, idle cycle between bursts
    rst         = 1'b0;
    bus.req_vld = 4'b1010;
    push(2'd1, 4'hA, 1'b0); push(2'd1, 4'hA, 1'b1);
    push(2'd3, 4'hC, 1'b0); push(2'd3, 4'hC, 1'b1);
    push(2'd1, 4'hA, 1'b0); push(2'd1, 4'hA, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rr_grant", bus.grant,    g_tab[i]);
      check("rr_last",  bus.agg_last, l_tab[i]);
    end
    bus.req_vld = 4'b0000;

    // A late request from 2 cannot interrupt requester 0's burst
    bus.req_vld = 4'b0001;
    push(2'd0, 4'h5, 1'b0); push(2'd0, 4'h5, 1'b1);
    push(2'd2, 4'h3, 1'b0); push(2'd2, 4'h3, 1'b1);
    tick();
    check("hold_grant0", bus.grant, 4'b0001);
    tick();
    bus.req_vld = 4'b0101;
    check("hold_grant1", bus.grant,    4'b0001);
    check("hold_last",   bus.agg_last, 1);
    tick();
    check("hold_idle", bus.grant, 4'b0000);
    bus.req_vld = 4'b0100;
    tick();
    check("hold_next", bus.grant, 4'b0100);
    tick();
    tick();
    bus.req_vld = 4'b0000;
    check("hold_done", bus.grant, 4'b0000);

    // Stalled burst: data tracks requester, no progress, timeout after 16
    bus.req_vld = 4'b0010;
    bus.agg_rdy = 1'b0;
    tick();
    check("stall_grant",   bus.grant,   4'b0010);
    check("stall_agg_vld", bus.agg_vld, 1);
    check("stall_req_rdy", bus.req_rdy, 0);
    for (int c = 1; c <= 16; c++) begin
      bus.req_data[7:4] = 4'(c);
      tick();
      check("stall_err", bus.err_stall, (c == 16));
      if (c <= 5) begin
        check("stall_data",    bus.agg_data, 4'(c));
        check("stall_req_rdy", bus.req_rdy,  0);
        check("stall_last",    bus.agg_last, 0);
      end
    end
    bus.req_data[7:4] = 4'hA;
    tick();
    tick();
    check("tmo_sticky", bus.err_stall, 1);
    check("tmo_grant",  bus.grant,     4'b0010);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("tmo_clr", bus.err_stall, 0);
    push(2'd1, 4'hA, 1'b0);
    bus.agg_rdy = 1'b1;
    tick();
    bus.agg_rdy = 1'b0;
    check("tmo_beat1_last", bus.agg_last,  1);
    check("tmo_err_after",  bus.err_stall, 0);
    for (int c = 1; c <= 16; c++) begin
      if (c == 16) bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      if (c >= 15) check("tmo_set_wins", bus.err_stall, (c == 16));
    end
    push(2'd1, 4'hA, 1'b1);
    bus.agg_rdy = 1'b1;
    tick();
    bus.req_vld = 4'b0000;
    check("tmo_done", bus.grant, 4'b0000);

    // Reset mid-burst abandons it; arbitration restarts at index 0
    bus.req_vld = 4'b1111;
    push(2'd2, 4'h3, 1'b0);
    tick();
    check("mid_grant",   bus.grant,     4'b0100);
    check("mid_err_held", bus.err_stall, 1);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_vld",  bus.agg_vld,  0);
    check("mid_rst_rdy",  bus.req_rdy,  0);
    check("mid_rst_last", bus.agg_last, 0);
    tick();
    check("post_rst_grant", bus.grant,     0);
    check("post_rst_src",   bus.agg_src,   0);
    check("post_rst_err",   bus.err_stall, 0);
    check("post_rst_vld",   bus.agg_vld,   0);
    rst = 1'b0;
    tick();
    check("restart_grant", bus.grant,   4'b0001);
    check("restart_src",   bus.agg_src, 0);
    bus.req_vld = 4'b0000;
    push(2'd0, 4'h5, 1'b0); push(2'd0, 4'h5, 1'b1);
    tick();
    check("drop_vld",   bus.agg_vld, 0);
    check("drop_grant", bus.grant,   4'b0001);
    bus.req_vld = 4'b0001;
    tick();
    tick();
    bus.req_vld = 4'b0000;
    check("drop_done", bus.grant, 4'b0000);
    tick();
    tick();

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snd_rcv_agg_sched.md
SND_RCV_AGG_SCHED -- requirements
Module: snd_rcv_agg_sched

Interface
REQ-001 The block SHALL have parameter K, default 4, number of requesters sharing one aggregator (K>=2).
REQ-002 The block SHALL have parameter N, default 4, narrow beat width in bits.
REQ-003 The block SHALL have parameter M, default 2, beats per aggregated word (burst length, M>=2).
REQ-004 The block SHALL have parameter TMO, default 16, mid-burst stall limit in cycles.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_vld  in  K  per-requester beat valid.
REQ-008 req_data  in  K*N  per-requester beat; requester i occupies bits [i*N +: N].
REQ-009 req_rdy  out  K  per-requester ready.
REQ-010 agg_vld  out  1  beat valid toward the shared aggregator.
REQ-011 agg_data  out  N  beat toward the aggregator.
REQ-012 agg_rdy  in  1  aggregator ready.
REQ-013 agg_last  out  1  marks the M-th beat of a burst.
REQ-014 agg_src  out  clog2(K)  index of the granted requester.
REQ-015 grant  out  K  one-hot grant; all zero when no burst is active.
REQ-016 err_stall  out  1  sticky stall-timeout flag.
REQ-017 err_clr  in  1  clears err_stall.

Function
REQ-018 The block SHALL implement FSM states IDLE and BURST; reset state is IDLE.
REQ-019 In IDLE, when any req_vld bit is 1, the block SHALL select the first set bit at or cyclically after rr_ptr, register it into grant/agg_src, and enter BURST next cycle.
REQ-020 In IDLE, the block SHALL drive req_rdy=0, agg_vld=0, and grant=0.
REQ-021 In BURST with granted index g, the block SHALL drive agg_vld=req_vld[g], agg_data=req_data[g], req_rdy[g]=agg_rdy, and all other req_rdy bits 0, combinationally.
REQ-022 The block SHALL count a beat only when agg_vld and agg_rdy are both 1; beat_cnt width is clog2(M)+1.
REQ-023 The block SHALL assert agg_last exactly when in BURST and beat_cnt==M-1.
REQ-024 On the accepted beat with beat_cnt==M-1, the block SHALL set beat_cnt to 0, set rr_ptr to (g+1) mod K, clear grant, and return to IDLE.
REQ-025 Each burst SHALL therefore be followed by one IDLE cycle; there is no back-to-back grant.
REQ-026 Grant SHALL be held for the whole burst regardless of other requests; bursts from different requesters never interleave.
REQ-027 A request in IDLE cycle t SHALL yield agg_vld at cycle t+1 at the earliest; minimum burst duration is M cycles.
REQ-028 rr_ptr SHALL be unchanged when no burst completes.
REQ-029 In BURST, stall_cnt SHALL count consecutive cycles without an accepted beat, saturating at TMO, and reset to 0 on any accepted beat or on leaving BURST.
REQ-030 When stall_cnt reaches TMO, the block SHALL set err_stall to 1; the grant and burst SHALL remain in place (no abort).
REQ-031 err_clr=1 SHALL clear err_stall; if a set condition and err_clr occur in the same cycle, set wins.
REQ-032 A requester dropping req_vld mid-burst SHALL keep the grant; agg_vld follows req_vld[g].

Reset
REQ-033 While rst=1, the block SHALL force state=IDLE, rr_ptr=0, beat_cnt=0, stall_cnt=0, grant=0, agg_src=0, err_stall=0.
REQ-034 Reset SHALL hold agg_vld, agg_last, and req_rdy at 0.
REQ-035 Reset asserted mid-burst SHALL abandon the burst immediately; the first post-reset arbitration starts from index 0.

Verification
REQ-036 K=4, M=2; req_vld=4'b1010 held, agg_rdy=1: grants SHALL be 1, then 3, then 1, with agg_last on every 2nd beat and one idle cycle between bursts.
REQ-037 Requester 0 is granted and beat 0 is accepted; req_vld[2] then rises: requester 0 SHALL complete beat 1 before any grant to requester 2.
REQ-038 In BURST, agg_rdy=0 for 5 cycles: beat_cnt SHALL stay constant, req_rdy[g] SHALL stay 0, agg_data SHALL track req_data[g], and err_stall SHALL stay 0.
REQ-039 TMO=16 with agg_rdy=0 for 16 cycles in BURST: err_stall SHALL rise and stay until err_clr; err_clr and a new timeout in the same cycle SHALL leave err_stall=1.
REQ-040 rst is pulsed after 1 of 2 beats: all outputs SHALL be 0 the next cycle, and with req_vld=4'b1111 the next grant SHALL be 4'b0001.
